fetch_group_issuer: RTL and testbench

- Producer side of the fetch-to-decode instruction buffer interface.
- Generates fetch-group PCs and issues one 3-word request at a time to instruction memory.
- Pre-decodes each returned group: extracts branch/JAL immediates, applies a static prediction, and truncates the group after the first predicted-taken slot.
- Drives `fetch_valid_o` with per-slot instruction/pc/imm/prediction into the buffer, honouring the buffer's `fetch_ready`; handles flush/redirect, including discarding an in-flight stale response.

---
 rtl/fetch_group_issuer.sv | 173 +++++++++++++++++
 tb/tb_fetch_group_issuer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_group_issuer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_group_issuer
// Purpose  : Fetches 3-word instruction groups, pre-decodes branch/JAL
//            immediates, applies static prediction and hands the group to
//            the instruction buffer. Optional macro: STATIC_BTFN_PREDICT_EN
//            (backward conditional branches predicted taken).
// Revision : 1.0 - initial release
// ============================================================================
module fetch_group_issuer #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   output logic                      imem_req_valid_o,
   input  logic                      imem_req_ready_i,
   output logic [DATA_WIDTH-1:0]     imem_req_addr_o,
   input  logic                      imem_resp_valid_i,
   input  logic [3*DATA_WIDTH-1:0]   imem_resp_data_i,
   output logic [2:0]                fetch_valid_o,
   output logic [DATA_WIDTH-1:0]     instruction_o_0,
   output logic [DATA_WIDTH-1:0]     instruction_o_1,
   output logic [DATA_WIDTH-1:0]     instruction_o_2,
   output logic [DATA_WIDTH-1:0]     pc_o_0,
   output logic [DATA_WIDTH-1:0]     pc_o_1,
   output logic [DATA_WIDTH-1:0]     pc_o_2,
   output logic [DATA_WIDTH-1:0]     imm_o_0,
   output logic [DATA_WIDTH-1:0]     imm_o_1,
   output logic [DATA_WIDTH-1:0]     imm_o_2,
   output logic                      branch_prediction_o_0,
   output logic                      branch_prediction_o_1,
   output logic                      branch_prediction_o_2,
   input  logic                      fetch_ready_i,
   input  logic                      flush_i,
   input  logic [DATA_WIDTH-1:0]     redirect_pc_i
);

   localparam int              c_W     = DATA_WIDTH;
   localparam logic [c_W-1:0]  c_ALIGN = {{(c_W-2){1'b1}}, 2'b00};
   localparam logic [c_W-1:0]  c_GROUP = c_W'(12);
`ifdef STATIC_BTFN_PREDICT_EN
   localparam logic            c_BTFN  = 1'b1;
`else
   localparam logic            c_BTFN  = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } state_t;

   state_t          r_state;
   logic [c_W-1:0]  r_pc;
   logic [c_W-1:0]  r_next_pc;
   logic [2:0]      r_valid;
   logic [2:0]      r_pred;
   logic [c_W-1:0]  r_instr [3];
   logic [c_W-1:0]  r_slot_pc [3];
   logic [c_W-1:0]  r_imm [3];

   logic [c_W-1:0]  w_word [3];
   logic [c_W-1:0]  w_imm [3];
   logic [c_W-1:0]  w_pc [3];
   logic [2:0]      w_taken;
   logic [2:0]      w_grp_valid;
   logic [c_W-1:0]  w_next_pc;

   // Per-slot pre-decode of the returning group
   for (genvar k = 0; k < 3; k++) begin : g_slot
      logic w_is_br;
      logic w_is_jal;
      assign w_word[k]  = imem_resp_data_i[k*c_W +: c_W];
      assign w_is_br    = (w_word[k][6:0] == 7'b1100011);
      assign w_is_jal   = (w_word[k][6:0] == 7'b1101111);
      assign w_pc[k]    = r_pc + c_W'(4*k);
      assign w_imm[k]   = w_is_br  ? {{(c_W-12){w_word[k][31]}}, w_word[k][7],
                                      w_word[k][30:25], w_word[k][11:8], 1'b0} :
                          w_is_jal ? {{(c_W-20){w_word[k][31]}}, w_word[k][19:12],
                                      w_word[k][20], w_word[k][30:21], 1'b0} :
                                     '0;
      assign w_taken[k] = w_is_jal | (c_BTFN & w_is_br & w_imm[k][c_W-1]);
   end

   // The first predicted-taken slot ends the group and supplies the target
   always_comb begin
      w_grp_valid = 3'b111;
      w_next_pc   = r_pc + c_GROUP;
      if (w_taken[0]) begin
         w_grp_valid = 3'b001;
         w_next_pc   = w_pc[0] + w_imm[0];
      end else if (w_taken[1]) begin
         w_grp_valid = 3'b011;
         w_next_pc   = w_pc[1] + w_imm[1];
      end else if (w_taken[2]) begin
         w_next_pc   = w_pc[2] + w_imm[2];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_REQ;
         r_pc      <= RESET_PC & c_ALIGN;
         r_next_pc <= '0;
         r_valid   <= '0;
         r_pred    <= '0;
         for (int k = 0; k < 3; k++) begin
            r_instr[k]   <= '0;
            r_slot_pc[k] <= '0;
            r_imm[k]     <= '0;
         end
      end else if (flush_i) begin
         r_pc    <= redirect_pc_i & c_ALIGN;
         r_valid <= '0;
         // A request already handed to memory must have its response drained
         unique case (r_state)
            S_REQ:   r_state <= imem_req_ready_i  ? S_DROP : S_REQ;
            S_WAIT:  r_state <= imem_resp_valid_i ? S_REQ  : S_DROP;
            S_DROP:  r_state <= imem_resp_valid_i ? S_REQ  : S_DROP;
            default: r_state <= S_REQ;
         endcase
      end else begin
         unique case (r_state)
            S_REQ: begin
               if (imem_req_ready_i) r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (imem_resp_valid_i) begin
                  r_state   <= S_HOLD;
                  r_valid   <= w_grp_valid;
                  r_pred    <= w_taken & w_grp_valid;
                  r_next_pc <= w_next_pc;
                  for (int k = 0; k < 3; k++) begin
                     r_instr[k]   <= w_word[k];
                     r_slot_pc[k] <= w_pc[k];
                     r_imm[k]     <= w_imm[k];
                  end
               end
            end
            S_HOLD: begin
               if (fetch_ready_i) begin
                  r_state <= S_REQ;
                  r_valid <= '0;
                  r_pc    <= r_next_pc & c_ALIGN;
               end
            end
            default: begin
               if (imem_resp_valid_i) r_state <= S_REQ;
            end
         endcase
      end
   end

   assign imem_req_valid_o      = (r_state == S_REQ) & reset & ~flush_i;
   assign imem_req_addr_o       = r_pc;
   assign fetch_valid_o         = r_valid;
   assign instruction_o_0       = r_instr[0];
   assign instruction_o_1       = r_instr[1];
   assign instruction_o_2       = r_instr[2];
   assign pc_o_0                = r_slot_pc[0];
   assign pc_o_1                = r_slot_pc[1];
   assign pc_o_2                = r_slot_pc[2];
   assign imm_o_0               = r_imm[0];
   assign imm_o_1               = r_imm[1];
   assign imm_o_2               = r_imm[2];
   assign branch_prediction_o_0 = r_pred[0];
   assign branch_prediction_o_1 = r_pred[1];
   assign branch_prediction_o_2 = r_pred[2];

endmodule
`default_nettype wire

// File: tb/tb_fetch_group_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_group_issuer
// Purpose  : Directed and randomized checks of fetch_group_issuer against a
//            group-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_group_issuer;

   localparam logic [31:0] c_RPC = 32'h0000_0100;
   localparam logic [31:0] c_NOP = 32'h0000_0013;
`ifdef STATIC_BTFN_PREDICT_EN
   localparam logic        c_BTFN = 1'b1;
`else
   localparam logic        c_BTFN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid_o;
   logic        imem_req_ready_i;
   logic [31:0] imem_req_addr_o;
   logic        imem_resp_valid_i;
   logic [95:0] imem_resp_data_i;
   logic [2:0]  fetch_valid_o;
   logic [31:0] instruction_o_0, instruction_o_1, instruction_o_2;
   logic [31:0] pc_o_0, pc_o_1, pc_o_2;
   logic [31:0] imm_o_0, imm_o_1, imm_o_2;
   logic        branch_prediction_o_0, branch_prediction_o_1, branch_prediction_o_2;
   logic        fetch_ready_i;
   logic        flush_i;
   logic [31:0] redirect_pc_i;

   fetch_group_issuer #(.DATA_WIDTH(32), .RESET_PC(c_RPC)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .imem_req_valid_o      (imem_req_valid_o),
      .imem_req_ready_i      (imem_req_ready_i),
      .imem_req_addr_o       (imem_req_addr_o),
      .imem_resp_valid_i     (imem_resp_valid_i),
      .imem_resp_data_i      (imem_resp_data_i),
      .fetch_valid_o         (fetch_valid_o),
      .instruction_o_0       (instruction_o_0),
      .instruction_o_1       (instruction_o_1),
      .instruction_o_2       (instruction_o_2),
      .pc_o_0                (pc_o_0),
      .pc_o_1                (pc_o_1),
      .pc_o_2                (pc_o_2),
      .imm_o_0               (imm_o_0),
      .imm_o_1               (imm_o_1),
      .imm_o_2               (imm_o_2),
      .branch_prediction_o_0 (branch_prediction_o_0),
      .branch_prediction_o_1 (branch_prediction_o_1),
      .branch_prediction_o_2 (branch_prediction_o_2),
      .fetch_ready_i         (fetch_ready_i),
      .flush_i               (flush_i),
      .redirect_pc_i         (redirect_pc_i)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_pc;
   logic [31:0] g_instr [3];
   logic [31:0] g_imm   [3];
   logic [2:0]  g_taken;
   logic [2:0]  e_valid;
   logic [31:0] e_next;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Build a slot from a chosen kind and immediate; expected imm is the chosen value
   task automatic set_slot(input int k, input int kind, input logic [31:0] imm);
      logic [31:0] r;
      r = $urandom;
      if (kind == 1) begin
         g_instr[k] = {imm[12], imm[10:5], r[24:20], r[19:15], 3'b000, imm[4:1], imm[11], 7'b1100011};
         g_imm[k]   = imm;
         g_taken[k] = c_BTFN & imm[31];
      end else if (kind == 2) begin
         g_instr[k] = {imm[20], imm[10:1], imm[11], imm[19:12], r[11:7], 7'b1101111};
         g_imm[k]   = imm;
         g_taken[k] = 1'b1;
      end else begin
         g_instr[k] = {r[31:7], 7'b0010011};
         g_imm[k]   = 32'h0;
         g_taken[k] = 1'b0;
      end
   endtask

   task automatic set_nops();
      for (int k = 0; k < 3; k++) begin
         g_instr[k] = c_NOP; g_imm[k] = 32'h0; g_taken[k] = 1'b0;
      end
   endtask

   // Reference: group ends at first predicted-taken slot
   task automatic model(input logic [31:0] base);
      bit found;
      found  = 0;
      e_valid = 3'b000;
      e_next = base + 32'd12;
      for (int k = 0; k < 3; k++) begin
         if (!found) begin
            e_valid[k] = 1'b1;
            if (g_taken[k]) begin
               e_next = base + 32'(4*k) + g_imm[k];
               found  = 1;
            end
         end
      end
   endtask

   function automatic logic [31:0] o_instr(input int k);
      case (k) 0: return instruction_o_0; 1: return instruction_o_1; default: return instruction_o_2; endcase
   endfunction
   function automatic logic [31:0] o_pc(input int k);
      case (k) 0: return pc_o_0; 1: return pc_o_1; default: return pc_o_2; endcase
   endfunction
   function automatic logic [31:0] o_imm(input int k);
      case (k) 0: return imm_o_0; 1: return imm_o_1; default: return imm_o_2; endcase
   endfunction
   function automatic logic o_pred(input int k);
      case (k) 0: return branch_prediction_o_0; 1: return branch_prediction_o_1; default: return branch_prediction_o_2; endcase
   endfunction

   task automatic check_group(input logic [31:0] base);
      check("fetch_valid", 32'(fetch_valid_o), 32'(e_valid));
      for (int k = 0; k < 3; k++) begin
         if (e_valid[k]) begin
            check($sformatf("instr%0d", k), o_instr(k), g_instr[k]);
            check($sformatf("pc%0d", k), o_pc(k), base + 32'(4*k));
            check($sformatf("imm%0d", k), o_imm(k), g_imm[k]);
            check($sformatf("pred%0d", k), 32'(o_pred(k)), 32'(g_taken[k]));
         end
      end
   endtask

   task automatic wait_req();
      int n;
      n = 0;
      while (!imem_req_valid_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("req_valid", 32'(imem_req_valid_o), 32'd1);
      check("req_addr", imem_req_addr_o, exp_pc);
   endtask

   // One full group: request, response after lat cycles, stall, accept or flush
   task automatic run_group(input int lat, input int stall, input bit do_flush, input logic [31:0] rpc);
      logic [31:0] base;
      wait_req();
      base = exp_pc;
      model(base);
      imem_req_ready_i = 1'b1;
      @(negedge clk);
      imem_req_ready_i = 1'b0;
      check("req_after_accept", 32'(imem_req_valid_o), 32'd0);
      repeat (lat - 1) @(negedge clk);
      imem_resp_valid_i = 1'b1;
      imem_resp_data_i  = {g_instr[2], g_instr[1], g_instr[0]};
      @(negedge clk);
      imem_resp_valid_i = 1'b0;
      imem_resp_data_i  = {$urandom, $urandom, $urandom};
      check_group(base);
      if (do_flush) begin
         flush_i = 1'b1; redirect_pc_i = rpc; fetch_ready_i = 1'b1;
         @(negedge clk);
         flush_i = 1'b0; fetch_ready_i = 1'b0;
         check("flush_hold_valid", 32'(fetch_valid_o), 32'd0);
         exp_pc = rpc & 32'hFFFF_FFFC;
         return;
      end
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check("stall_req", 32'(imem_req_valid_o), 32'd0);
         check_group(base);
      end
      fetch_ready_i = 1'b1;
      @(negedge clk);
      fetch_ready_i = 1'b0;
      check("valid_after_accept", 32'(fetch_valid_o), 32'd0);
      check("next_req_valid", 32'(imem_req_valid_o), 32'd1);
      exp_pc = e_next;
      check("next_req_addr", imem_req_addr_o, exp_pc);
   endtask

   initial begin
      reset = 1'b0;
      imem_req_ready_i = 1'b0; imem_resp_valid_i = 1'b0; imem_resp_data_i = '0;
      fetch_ready_i = 1'b0; flush_i = 1'b0; redirect_pc_i = '0;
      repeat (3) @(negedge clk);
      check("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
      check("rst_fetch_valid", 32'(fetch_valid_o), 32'd0);
      check("rst_pc0", pc_o_0, 32'd0);
      check("rst_instr0", instruction_o_0, 32'd0);
      check("rst_imm0", imm_o_0, 32'd0);
      check("rst_pred0", 32'(branch_prediction_o_0), 32'd0);
      reset = 1'b1;
      exp_pc = c_RPC;

      // Straight-line NOP groups: 0x100, 0x10C, 0x118
      set_nops();
      repeat (3) run_group(1, 0, 0, 0);

      // Redirect while in REQ: request gated in the same cycle
      @(negedge clk);
      flush_i = 1'b1; redirect_pc_i = 32'h0000_0100;
      #1 check("flush_req_gate", 32'(imem_req_valid_o), 32'd0);
      @(negedge clk);
      flush_i = 1'b0;
      exp_pc = 32'h0000_0100;

      // JAL -8 in slot 1 -> truncated, target 0x0FC
      set_nops();
      g_instr[1] = 32'hFF9F_F06F; g_imm[1] = 32'hFFFF_FFF8; g_taken[1] = 1'b1;
      run_group(1, 0, 0, 0);
      check("jal_target", exp_pc, 32'h0000_00FC);

      // Forward BEQ +16 -> not taken
      set_nops();
      g_instr[0] = 32'h0000_0863; g_imm[0] = 32'h0000_0010; g_taken[0] = 1'b0;
      run_group(1, 0, 0, 0);

      // Backward BEQ -4 -> taken only with static BTFN prediction
      set_nops();
      g_instr[0] = 32'hFE00_0EE3; g_imm[0] = 32'hFFFF_FFFC; g_taken[0] = c_BTFN;
      run_group(2, 0, 0, 0);

      // Buffer back-pressure for 5 cycles
      set_nops();
      run_group(1, 5, 0, 0);

      // Flush in WAIT; stale junk response 3 cycles later must be discarded
      wait_req();
      imem_req_ready_i = 1'b1;
      @(negedge clk);
      imem_req_ready_i = 1'b0;
      flush_i = 1'b1; redirect_pc_i = 32'h0000_0203;
      @(negedge clk);
      flush_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check("drop_valid", 32'(fetch_valid_o), 32'd0);
         check("drop_req", 32'(imem_req_valid_o), 32'd0);
         @(negedge clk);
      end
      imem_resp_valid_i = 1'b1; imem_resp_data_i = {3{32'hFF9F_F06F}};
      @(negedge clk);
      imem_resp_valid_i = 1'b0;
      check("drop_junk_valid", 32'(fetch_valid_o), 32'd0);
      exp_pc = 32'h0000_0200;
      set_nops();
      run_group(1, 0, 0, 0);

      // Flush in HOLD overrides ready; then address wrap at 2^32
      run_group(1, 0, 1, 32'hFFFF_FFFB);
      run_group(1, 0, 0, 0);
      check("wrap_target", exp_pc, 32'h0000_0004);

      // Randomized groups
      for (int n = 0; n < 40; n++) begin
         for (int k = 0; k < 3; k++) begin
            int kind;
            logic [31:0] imm;
            kind = $urandom_range(0, 3);
            if (kind == 2) begin
               imm = (32'($urandom_range(0, 2047)) << 2) - 32'd4096;
               set_slot(k, 1, imm);
            end else if (kind == 3) begin
               imm = (32'($urandom_range(0, 262143)) << 2) - 32'h0010_0000;
               set_slot(k, 2, imm);
            end else begin
               set_slot(k, 0, 32'h0);
            end
         end
         run_group($urandom_range(1, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 7) == 0), $urandom);
      end

      // Reset mid-WAIT; the late response lands in REQ and is ignored
      wait_req();
      imem_req_ready_i = 1'b1;
      @(negedge clk);
      imem_req_ready_i = 1'b0;
      reset = 1'b0;
      #1;
      check("mid_rst_req", 32'(imem_req_valid_o), 32'd0);
      check("mid_rst_valid", 32'(fetch_valid_o), 32'd0);
      check("mid_rst_pc0", pc_o_0, 32'd0);
      check("mid_rst_instr0", instruction_o_0, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      imem_resp_valid_i = 1'b1; imem_resp_data_i = {3{32'h1234_5678}};
      @(negedge clk);
      imem_resp_valid_i = 1'b0;
      check("late_resp_valid", 32'(fetch_valid_o), 32'd0);
      exp_pc = c_RPC;
      set_nops();
      run_group(1, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
